sccb_master: RTL and testbench
==============================

Name: sccb_master

Overview:
- Parametrised SCCB/I2C-style master for camera register configuration. Successor to the write-only sender.
- Adds a valid/ready command handshake and configurable bus rate.
- Adds 8- or 16-bit register addressing and SCCB 2-phase reads with read-data return.
- Adds optional ACK checking with error reporting, and open-drain SIOD drive.
- Sits between the register-init ROM sequencer and the camera SIOC/SIOD pins.

Parameters:
- CLK_DIV, 64, clk cycles per quarter SIOC period (min 2); SIOC period = 4*CLK_DIV clocks.
- ADDR_W, 8, register address width, 8 or 16 (sent MSB byte first).
- CHECK_ACK, 0, 1 = abort the transaction when a write-byte 9th bit samples high.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_id  in  8  device write ID; bit0 ignored (forced 0 for write phases, 1 for read phase).
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  8  write data (ignored on read).
- busy  out  1  transaction in progress (= ~cmd_ready).
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  NACK seen in last transaction; valid from done, held until next accept.
- rdata  out  8  last read byte; updated only on a successful read, held otherwise.
- sioc  out  1  SCCB clock, driven push-pull.
- siod  inout  1  SCCB data, open-drain: drives 0, releases (Z) for 1; external pull-up.

Behaviour:
- Reset (async) values: state IDLE, cmd_ready=1, busy=0, done=0, err=0, rdata=0, sioc=1, siod=Z, quarter counter=0.
- Reset mid-transaction releases the bus immediately (sioc=1, siod=Z); no stop condition is generated.
- Accept: rising edge with cmd_valid&&cmd_ready latches rw/id/addr/wdata, clears err, and sets cmd_ready=0 from the next cycle.
- Timing unit: one quarter = CLK_DIV clocks. Every symbol is exactly 4 quarters (q0..q3).
- START: q0,q1 siod=1/sioc=1; q2 siod=0/sioc=1; q3 siod=0/sioc=0.
- BIT: q0,q1 sioc=0, siod driven from bit at start of q0; q2,q3 sioc=1.
- Sampling: siod is sampled on the last clock of q2.
- STOP: q0 siod=0/sioc=0; q1,q2 siod=0/sioc=1; q3 siod=Z/sioc=1.
- BYTE: 8 data bits MSB first, then 9th bit with siod released; master samples it as ACK.
- State machine: IDLE -> START -> BYTE (repeats) -> STOP -> [START for read phase 2] -> DONE -> IDLE.
- Write sequence: START, {id,0}, addr byte(s), wdata, STOP. N = 2 + ADDR_W/8 bytes.
- Read sequence: START, {id,0}, addr byte(s), STOP, START, {id,1}, read byte, 9th bit driven 1 (NA), STOP.
  - During the read byte siod is released; each bit is sampled in q2 and shifted into rdata on completion.
- ACK check (CHECK_ACK=1): if a write-direction 9th bit samples 1, set err=1, skip remaining bytes and phases, go to STOP, then DONE. rdata is not updated.
- CHECK_ACK=0: 9th bit is don't-care and err stays 0.
- DONE: lasts one clock with done=1 and cmd_ready=1 in the same cycle; a new command may be accepted on that edge.
- Latency, accept edge to done: (8 + 36*N)*CLK_DIV clocks for a write; (16 + 36*(3 + ADDR_W/8))*CLK_DIV for a read.
- cmd_valid is ignored while busy; command fields are not re-sampled mid-transaction.

Test Plan:
- Write, CLK_DIV=4, ADDR_W=8, id=0x42, addr=0x12, wdata=0x80, slave always ACKs -> decoded bus bytes 0x42,0x12,0x80 with start/stop; done exactly 464 clocks after accept; err=0.
- Read, CLK_DIV=4, ADDR_W=8, id=0x43 (bit0 ignored), addr=0x0A, slave returns 0x76 -> bus shows 0x42,0x0A,STOP,START,0x43; NA bit =1; rdata=0x76; done at 640 clocks.
- ADDR_W=16 write, addr=0x3008, wdata=0x82 -> bytes 0x42,0x30,0x08,0x82; done at 608 clocks with CLK_DIV=4.
- CHECK_ACK=1, slave NACKs the address byte -> no data byte sent, STOP follows, done with err=1, rdata unchanged; the next good command clears err.
- Back-to-back: cmd_valid held high with two writes -> second accepted on the done edge; no idle clocks between the STOP q3 and the next START q0.
- Assert reset at quarter 50 of a write -> sioc=1, siod=Z, cmd_ready=1 immediately (asynchronous); a following write completes normally.

Source files
------------

// File: rtl/sccb_master.sv
// SCCB/I2C-style master for camera register configuration.
// Accepts one command per valid/ready handshake and runs a write or a
// two-phase SCCB read on SIOC/SIOD. Every bus symbol is four quarters of
// CLK_DIV clocks. Pin values are registered from the next-state position, so
// each quarter's levels appear on the clock edge that starts that quarter.
module sccb_master #(
  parameter int CLK_DIV   = 64,
  parameter int ADDR_W    = 8,
  parameter bit CHECK_ACK = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rw_i,
  input  logic [7:0]        cmd_id_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]        cmd_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        rdata_o,
  output logic              sioc_o,
  inout  wire               siod_io
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [1:0] AB = 2'(ADDR_W / 8);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          phase_q, phase_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rw_q;
  logic [6:0]    id_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          ready_q, busy_q, done_q;
  logic          sioc_q, sioc_d;
  logic          oe_q, oe_d;

  logic          accept_s, run_s, tick_s, samp_s, qend_s, reading_s, last_s;
  logic [1:0]    last_idx_s;
  logic          siod_s;
  logic          unused_s;

  assign siod_io  = oe_q ? 1'b0 : 1'bz;
  assign siod_s   = siod_io;
  assign unused_s = cmd_id_i[0];

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign sioc_o      = sioc_q;

  // Byte to shift out for a given phase and byte index (0xFF = bus released).
  function automatic logic [7:0] pick_byte(input logic ph, input logic [1:0] idx,
                                           input logic [6:0] id, input logic [15:0] addr,
                                           input logic [7:0] wd);
    logic [7:0] b;
    if (ph) begin
      b = (idx == 2'd0) ? {id, 1'b1} : 8'hFF;
    end else if (idx == 2'd0) begin
      b = {id, 1'b0};
    end else if (idx == AB) begin
      b = addr[7:0];
    end else if (idx < AB) begin
      b = addr[15:8];
    end else begin
      b = wd;
    end
    return b;
  endfunction

  assign accept_s   = cmd_valid_i && ready_q;
  assign run_s      = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);
  assign tick_s     = run_s && (cnt_q == CNT_LAST);
  assign samp_s     = tick_s && (qtr_q == 2'd2);
  assign qend_s     = tick_s && (qtr_q == 2'd3);
  assign reading_s  = phase_q && (byte_q == 2'd1);
  assign last_idx_s = phase_q ? 2'd1 : (rw_q ? AB : AB + 2'd1);
  assign last_s     = (byte_q == last_idx_s);

  // Next-state logic: quarter timing, symbol sequencing, shift and sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (run_s) begin
      cnt_d = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
      qtr_d = tick_s ? qtr_q + 2'd1 : qtr_q;
    end else begin
      cnt_d = {CW{1'b0}};
      qtr_d = 2'd0;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ST_START;
          byte_d  = 2'd0;
          phase_d = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (qend_s) begin
          state_d = ST_BIT;
          bit_d   = 4'd0;
          sh_d    = pick_byte(phase_q, byte_q, id_q, addr_q, wdata_q);
        end else begin
          state_d = ST_START;
        end
      end
      ST_BIT: begin
        if (samp_s) begin
          if (bit_q == 4'd8) begin
            ack_d = siod_s;
          end else if (reading_s) begin
            rx_d = {rx_q[6:0], siod_s};
          end else begin
            rx_d = rx_q;
          end
        end else begin
          rx_d = rx_q;
        end
        if (qend_s) begin
          if (bit_q != 4'd8) begin
            bit_d = bit_q + 4'd1;
            sh_d  = {sh_q[6:0], 1'b1};
          end else if (reading_s) begin
            rdata_d = rx_q;
            state_d = ST_STOP;
          end else if (CHECK_ACK && ack_q) begin
            err_d   = 1'b1;
            state_d = ST_STOP;
          end else if (last_s) begin
            state_d = ST_STOP;
          end else begin
            byte_d = byte_q + 2'd1;
            bit_d  = 4'd0;
            sh_d   = pick_byte(phase_q, byte_q + 2'd1, id_q, addr_q, wdata_q);
          end
        end else begin
          state_d = ST_BIT;
        end
      end
      ST_STOP: begin
        if (qend_s) begin
          if (!phase_q && rw_q && !err_q) begin
            state_d = ST_START;
            phase_d = 1'b1;
            byte_d  = 2'd0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin levels for the bus position the machine is about to enter.
  always_comb begin
    sioc_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      ST_START: begin
        sioc_d = (qtr_d != 2'd3);
        oe_d   = qtr_d[1];
      end
      ST_BIT: begin
        sioc_d = qtr_d[1];
        oe_d   = (bit_d != 4'd8) && !(phase_d && (byte_d == 2'd1)) && !sh_d[7];
      end
      ST_STOP: begin
        sioc_d = (qtr_d != 2'd0);
        oe_d   = (qtr_d != 2'd3);
      end
      default: begin
        sioc_d = 1'b1;
        oe_d   = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset releases the bus at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      qtr_q   <= 2'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      phase_q <= 1'b0;
      sh_q    <= 8'hFF;
      rx_q    <= 8'h00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      id_q    <= 7'h00;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sioc_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept_s) begin
        rw_q    <= cmd_rw_i;
        id_q    <= cmd_id_i[7:1];
        addr_q  <= 16'(cmd_addr_i);
        wdata_q <= cmd_wdata_i;
      end else begin
        rw_q    <= rw_q;
        id_q    <= id_q;
        addr_q  <= addr_q;
        wdata_q <= wdata_q;
      end
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_q  <= !((state_d == ST_IDLE) || (state_d == ST_DONE));
      done_q  <= (state_d == ST_DONE);
      sioc_q  <= sioc_d;
      oe_q    <= oe_d;
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: three instances (8-bit addr, 16-bit addr,
// ACK-checking) share one open-drain SIOD line with a behavioural slave that
// decodes START/STOP/bytes and answers ACKs and read data.
module tb_sccb_master;

  localparam int S = 32'h1000;
  localparam int P = 32'h2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = 3'b000;
  logic        rw = 1'b0;
  logic [7:0]  id = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wd = 8'h00;
  logic [2:0]  ready_w, busy_w, done_w, err_w, sioc_w;
  logic [7:0]  rdata0, rdata1, rdata2;
  wire         siod_w;
  logic        sioc_bus;

  logic        slv_oe = 1'b0;
  logic [7:0]  rd_byte = 8'h76;
  int          nack_byte = -1;
  int          ev[$];
  int          exp_ev[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          lat;

  pullup (siod_w);
  assign siod_w   = slv_oe ? 1'b0 : 1'bz;
  assign sioc_bus = &sioc_w;

  always #5 clk = ~clk;

  sccb_master #(.CLK_DIV(4), .ADDR_W(8), .CHECK_ACK(1'b0)) u0 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(vld[0]), .cmd_ready_o(ready_w[0]),
    .cmd_rw_i(rw), .cmd_id_i(id), .cmd_addr_i(addr[7:0]), .cmd_wdata_i(wd),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .err_o(err_w[0]), .rdata_o(rdata0),
    .sioc_o(sioc_w[0]), .siod_io(siod_w));

  sccb_master #(.CLK_DIV(4), .ADDR_W(16), .CHECK_ACK(1'b0)) u1 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(vld[1]), .cmd_ready_o(ready_w[1]),
    .cmd_rw_i(rw), .cmd_id_i(id), .cmd_addr_i(addr), .cmd_wdata_i(wd),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .err_o(err_w[1]), .rdata_o(rdata1),
    .sioc_o(sioc_w[1]), .siod_io(siod_w));

  sccb_master #(.CLK_DIV(4), .ADDR_W(8), .CHECK_ACK(1'b1)) u2 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(vld[2]), .cmd_ready_o(ready_w[2]),
    .cmd_rw_i(rw), .cmd_id_i(id), .cmd_addr_i(addr[7:0]), .cmd_wdata_i(wd),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .err_o(err_w[2]), .rdata_o(rdata2),
    .sioc_o(sioc_w[2]), .siod_io(siod_w));

  // Bus monitor and slave: decode on the falling system clock, drive ACK/data while SIOC is low.
  logic       pc = 1'b1, pd = 1'b1, active = 1'b0, dir = 1'b0;
  int         bitn = 0, bytenum = 0;
  logic [7:0] shb = 8'h00;
  always @(negedge clk) begin
    logic c, d;
    c = sioc_bus;
    d = siod_w;
    if (rst) begin
      slv_oe = 1'b0;
      active = 1'b0;
    end else if (pc && c && pd && !d) begin
      ev.push_back(S);
      bitn = 0; bytenum = 0; active = 1'b1; slv_oe = 1'b0;
    end else if (pc && c && !pd && d) begin
      ev.push_back(P);
      active = 1'b0;
    end else if (!pc && c && active) begin
      if (bitn < 8) begin
        shb = {shb[6:0], d};
        bitn = bitn + 1;
      end else begin
        ev.push_back(int'(shb) + (d ? 32'h100 : 32'h0));
        if (bytenum == 0) dir = shb[0];
        bytenum = bytenum + 1;
        bitn = 0;
      end
    end else if (pc && !c && active) begin
      slv_oe = 1'b0;
      if (bitn == 8 && !(dir && bytenum == 1)) slv_oe = (nack_byte != bytenum);
      else if (bitn < 8 && dir && bytenum == 1) slv_oe = !rd_byte[7 - bitn];
    end
    pc = c;
    pd = d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag);
    chk({tag, "_nev"}, ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size(); i++)
      chk(tag, (i < ev.size()) ? ev[i] : -1, exp_ev[i]);
  endtask

  // Issue one command to instance u, then count clocks from accept edge to done.
  task automatic run_cmd(input int u, input logic r, input logic [7:0] i_id,
                         input logic [15:0] a, input logic [7:0] w, output int n);
    @(negedge clk);
    rw = r; id = i_id; addr = a; wd = w;
    vld[u] = 1'b1;
    @(posedge clk); #1;
    vld[u] = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!done_w[u] && n < 5000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_w[0], 1'b1);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_done", done_w[0], 1'b0);
    chk("rst_err", err_w[0], 1'b0);
    chk("rst_rdata", rdata0, 8'h00);
    chk("rst_sioc", sioc_bus, 1'b1);
    chk("rst_siod", siod_w, 1'b1);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    // Plain write, 8-bit address.
    ev.delete();
    run_cmd(0, 1'b0, 8'h42, 16'h0012, 8'h80, lat);
    chk("wr_lat", lat, 464);
    chk("wr_err", err_w[0], 1'b0);
    chk("wr_ready_at_done", ready_w[0], 1'b1);
    @(posedge clk); #1;
    chk("wr_done_pulse", done_w[0], 1'b0);
    exp_ev = '{S, 32'h042, 32'h012, 32'h080, P};
    chk_bus("wr_bus");

    // Two-phase read; id bit0 ignored, NA bit must read back as 1.
    ev.delete();
    run_cmd(0, 1'b1, 8'h43, 16'h000A, 8'h00, lat);
    chk("rd_lat", lat, 640);
    chk("rd_rdata", rdata0, 8'h76);
    chk("rd_err", err_w[0], 1'b0);
    exp_ev = '{S, 32'h042, 32'h00A, P, S, 32'h043, 32'h176, P};
    chk_bus("rd_bus");

    // 16-bit address write.
    ev.delete();
    run_cmd(1, 1'b0, 8'h42, 16'h3008, 8'h82, lat);
    chk("w16_lat", lat, 608);
    exp_ev = '{S, 32'h042, 32'h030, 32'h008, 32'h082, P};
    chk_bus("w16_bus");

    // ACK-checking instance: good read, then NACK on the address byte.
    ev.delete();
    rd_byte = 8'h5C;
    run_cmd(2, 1'b1, 8'h42, 16'h0021, 8'h00, lat);
    chk("ck_rd_rdata", rdata2, 8'h5C);
    chk("ck_rd_err", err_w[2], 1'b0);
    ev.delete();
    nack_byte = 1;
    rd_byte = 8'hA5;
    run_cmd(2, 1'b1, 8'h42, 16'h000A, 8'h00, lat);
    nack_byte = -1;
    chk("nack_lat", lat, 320);
    chk("nack_err", err_w[2], 1'b1);
    chk("nack_rdata_held", rdata2, 8'h5C);
    exp_ev = '{S, 32'h042, 32'h10A, P};
    chk_bus("nack_bus");
    repeat (3) @(posedge clk); #1;
    chk("nack_err_hold", err_w[2], 1'b1);
    run_cmd(2, 1'b0, 8'h42, 16'h0033, 8'h44, lat);
    chk("good_after_nack_lat", lat, 464);
    chk("good_after_nack_err", err_w[2], 1'b0);

    // Back-to-back writes with cmd_valid held high.
    ev.delete();
    @(negedge clk);
    rw = 1'b0; id = 8'h42; addr = 16'h0012; wd = 8'hA1;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    wd = 8'hB2;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!done_w[0] && lat < 5000);
    chk("b2b_lat1", lat, 464);
    chk("b2b_ready_at_done", ready_w[0], 1'b1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("b2b_busy_after_done", busy_w[0], 1'b1);
    chk("b2b_done_low", done_w[0], 1'b0);
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!done_w[0] && lat < 5000);
    chk("b2b_lat2", lat, 464);
    exp_ev = '{S, 32'h042, 32'h012, 32'h0A1, P, S, 32'h042, 32'h012, 32'h0B2, P};
    chk_bus("b2b_bus");

    // Asynchronous reset at quarter 50 of a write, then a clean write.
    @(negedge clk);
    rw = 1'b0; id = 8'h42; addr = 16'h0012; wd = 8'h80;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_sioc", sioc_bus, 1'b1);
    chk("arst_siod", siod_w, 1'b1);
    chk("arst_ready", ready_w[0], 1'b1);
    chk("arst_busy", busy_w[0], 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    ev.delete();
    run_cmd(0, 1'b0, 8'h42, 16'h0012, 8'h80, lat);
    chk("post_rst_lat", lat, 464);
    exp_ev = '{S, 32'h042, 32'h012, 32'h080, P};
    chk_bus("post_rst_bus");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
